aclk_time_entry: RTL and testbench
==================================

Name: aclk_time_entry

Overview:
- Upstream user-entry stage for the alarm clock.
- Converts button presses into BCD digits H_in1/H_in0/M_in1/M_in0, which drive the clock core's setting inputs.
- Issues a single-cycle LD_time or LD_alarm pulse when the user confirms.
- Runs on the same 10 Hz clock as the clock core; its outputs connect directly to the core's setting inputs.

Parameters:
- TIMEOUT_TICKS, 300: idle ticks in an edit state (30 s at 10 Hz) before entry is abandoned without loading.
- CNT_W, 9: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_TICKS.

Ports:
- clk  in  1  10 Hz system clock, shared with the clock core.
- reset_n  in  1  asynchronous, active-low reset.
- mode_time  in  1  level button: start editing clock time.
- mode_alarm  in  1  level button: start editing alarm time.
- btn_inc  in  1  level button: increment the selected digit.
- btn_next  in  1  level button: select the next digit.
- btn_ok  in  1  level button: commit the entry.
- btn_cancel  in  1  level button: abandon the entry.
- H_in1  out  2  hour tens digit (0..2).
- H_in0  out  4  hour units digit (0..9, or 0..3 when H_in1=2).
- M_in1  out  4  minute tens digit (0..5).
- M_in0  out  4  minute units digit (0..9).
- LD_time  out  1  one-cycle load strobe to the clock register.
- LD_alarm  out  1  one-cycle load strobe to the alarm register.
- editing  out  1  high in any EDIT state.
- digit_sel  out  2  selected digit: 0=H1, 1=H0, 2=M1, 3=M0; 0 outside edit.

Behaviour:
- All button inputs are synchronous to clk. The block registers each input and acts only on a rising edge (prev=0, cur=1). A held button produces exactly one event.
- Reset (reset_n=0, asynchronous):
  - State=IDLE.
  - All digits 0; LD_time=LD_alarm=0; editing=0; digit_sel=0.
  - Timeout counter 0; edge-detect history 0.
- States: IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, LOAD.
- IDLE:
  - mode_time edge -> EDIT_H1 with target=TIME; mode_alarm edge -> EDIT_H1 with target=ALARM.
  - Both edges in the same cycle -> target=TIME.
  - On entry, all four digits clear to 0.
  - Other button edges in IDLE are ignored.
- EDIT_x, event priority within a cycle: cancel > ok > next > inc. Only the highest-priority event acts.
  - cancel -> IDLE. No strobe; digits keep their current values.
  - ok -> LOAD.
  - next -> advance H1->H0->M1->M0->H1 (wraps).
  - inc -> increment the selected digit modulo its range:
    - H1: 0..2.
    - H0: 0..9 if H1<2, else 0..3.
    - M1: 0..5.
    - M0: 0..9.
  - H1 fixup: when H1 becomes 2 and H0>3, H0 is forced to 0 in the same cycle.
  - mode_time/mode_alarm edges in edit states are ignored; the target stays latched.
- LOAD: lasts one cycle.
  - Asserts LD_time (target=TIME) or LD_alarm (target=ALARM) for exactly that cycle, then -> IDLE.
  - Digits are stable during that cycle and hold afterwards.
  - Button edges during LOAD are ignored.
- Latency: ok edge sampled at cycle N -> strobe high in cycle N+1 -> IDLE in cycle N+2.
- Timeout counter:
  - Counts every cycle in EDIT states.
  - Clears on entry to EDIT and on any button edge.
  - On reaching TIMEOUT_TICKS-1 -> IDLE with no strobe; counter clears.
- Strobe exclusivity: LD_time and LD_alarm are never high together and never high outside LOAD.
- Output registration: all outputs are registered; digits never take an out-of-range value in any cycle.
- Reset mid-operation (including during LOAD): immediate IDLE; the strobe deasserts asynchronously.

Test Plan:
- Reset, mode_time edge, inc×1 (H1=1), next, inc×3 (H0=3), next, inc×4 (M1=4), next, inc×5 (M0=5), ok -> digits 1,3,4,5; LD_time high exactly 1 cycle; LD_alarm stays 0; editing falls.
- mode_alarm edge, H1 inc×3 -> H1 goes 1,2,0; set H1=1, H0=9, then H1=2 -> H0 forced to 0. Confirm with ok -> LD_alarm pulse with 2,0,0,0.
- Edit M1 inc×6 -> 1,2,3,4,5,0; next×4 from H1 -> digit_sel 1,2,3,0.
- Edit, cancel -> IDLE, no strobe. Edit with no buttons for 300 cycles -> IDLE at the timeout, no strobe. An inc at cycle 299 restarts the 300-cycle count.
- Same-cycle edges: ok+inc -> load with the digit unchanged. cancel+ok -> no strobe. mode_time+mode_alarm in IDLE -> later ok gives LD_time. btn_inc held 20 cycles -> single increment.
- reset_n low during the LOAD cycle -> LD_time drops immediately, digits 0, IDLE; after release, mode_time works normally.

Source files
------------

// File: rtl/aclk_time_entry.sv
// User-entry front end for the alarm clock: turns button edges into BCD
// setting digits and a one-cycle LD_time / LD_alarm strobe on confirm.
module aclk_time_entry #(
    parameter int TIMEOUT_TICKS = 300,
    parameter int CNT_W         = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_time,
    input  logic       mode_alarm,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_ok,
    input  logic       btn_cancel,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic [1:0] digit_sel
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDIT_H1 = 3'd1,
        S_EDIT_H0 = 3'd2,
        S_EDIT_M1 = 3'd3,
        S_EDIT_M0 = 3'd4,
        S_LOAD    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    state_t           r_state;
    logic             r_tgt_alarm;
    logic [5:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_h1;
    logic [3:0]       r_h0;
    logic [3:0]       r_m1;
    logic [3:0]       r_m0;
    logic             r_ld_time;
    logic             r_ld_alarm;
    logic             r_editing;
    logic [1:0]       r_digit_sel;

    logic [5:0]       w_btn;
    logic [5:0]       w_edge;
    logic             w_e_time, w_e_alarm, w_e_inc, w_e_next, w_e_ok, w_e_cancel;
    logic             w_in_edit;
    logic             w_nxt_edit;
    logic             w_timeout;
    logic             w_do_inc;
    logic [1:0]       w_h1_inc;
    state_t           w_nxt;

    function automatic logic [3:0] f_wrap_inc(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? 4'd0 : v + 4'd1;
    endfunction

    assign w_btn      = {btn_cancel, btn_ok, btn_next, btn_inc, mode_alarm, mode_time};
    assign w_edge     = w_btn & ~r_prev;
    assign w_e_time   = w_edge[0];
    assign w_e_alarm  = w_edge[1];
    assign w_e_inc    = w_edge[2];
    assign w_e_next   = w_edge[3];
    assign w_e_ok     = w_edge[4];
    assign w_e_cancel = w_edge[5];

    assign w_in_edit  = (r_state == S_EDIT_H1) || (r_state == S_EDIT_H0) ||
                        (r_state == S_EDIT_M1) || (r_state == S_EDIT_M0);
    assign w_nxt_edit = (w_nxt == S_EDIT_H1) || (w_nxt == S_EDIT_H0) ||
                        (w_nxt == S_EDIT_M1) || (w_nxt == S_EDIT_M0);
    // Any edge (even an ignored mode edge) counts as user activity and defers the timeout
    assign w_timeout  = w_in_edit && !(|w_edge) && (r_cnt == LP_CNT_LAST);
    assign w_do_inc   = w_in_edit && w_e_inc && !w_e_cancel && !w_e_ok && !w_e_next;
    assign w_h1_inc   = (r_h1 >= 2'd2) ? 2'd0 : r_h1 + 2'd1;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_e_time || w_e_alarm) w_nxt = S_EDIT_H1;
            end
            S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0: begin
                if (w_e_cancel)     w_nxt = S_IDLE;
                else if (w_e_ok)    w_nxt = S_LOAD;
                else if (w_e_next) begin
                    case (r_state)
                        S_EDIT_H1: w_nxt = S_EDIT_H0;
                        S_EDIT_H0: w_nxt = S_EDIT_M1;
                        S_EDIT_M1: w_nxt = S_EDIT_M0;
                        default:   w_nxt = S_EDIT_H1;
                    endcase
                end
                else if (w_timeout) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tgt_alarm <= 1'b0;
            r_prev      <= '0;
            r_cnt       <= '0;
            r_h1        <= '0;
            r_h0        <= '0;
            r_m1        <= '0;
            r_m0        <= '0;
            r_ld_time   <= 1'b0;
            r_ld_alarm  <= 1'b0;
            r_editing   <= 1'b0;
            r_digit_sel <= '0;
        end else begin
            r_prev    <= w_btn;
            r_state   <= w_nxt;
            r_editing <= w_nxt_edit;
            r_ld_time  <= (w_nxt == S_LOAD) && !r_tgt_alarm;
            r_ld_alarm <= (w_nxt == S_LOAD) &&  r_tgt_alarm;

            case (w_nxt)
                S_EDIT_H0: r_digit_sel <= 2'd1;
                S_EDIT_M1: r_digit_sel <= 2'd2;
                S_EDIT_M0: r_digit_sel <= 2'd3;
                default:   r_digit_sel <= 2'd0;
            endcase

            if (w_in_edit && w_nxt_edit && !(|w_edge)) r_cnt <= r_cnt + CNT_W'(1);
            else                                       r_cnt <= '0;

            if (r_state == S_IDLE && (w_e_time || w_e_alarm)) begin
                // Time wins a simultaneous press of both mode buttons
                r_tgt_alarm <= w_e_alarm && !w_e_time;
                r_h1 <= '0;
                r_h0 <= '0;
                r_m1 <= '0;
                r_m0 <= '0;
            end else if (w_do_inc) begin
                case (r_state)
                    S_EDIT_H1: begin
                        r_h1 <= w_h1_inc;
                        if (w_h1_inc == 2'd2 && r_h0 > 4'd3) r_h0 <= 4'd0;
                    end
                    S_EDIT_H0: r_h0 <= f_wrap_inc(r_h0, (r_h1 == 2'd2) ? 4'd3 : 4'd9);
                    S_EDIT_M1: r_m1 <= f_wrap_inc(r_m1, 4'd5);
                    default:   r_m0 <= f_wrap_inc(r_m0, 4'd9);
                endcase
            end
        end
    end

    assign H_in1     = r_h1;
    assign H_in0     = r_h0;
    assign M_in1     = r_m1;
    assign M_in0     = r_m0;
    assign LD_time   = r_ld_time;
    assign LD_alarm  = r_ld_alarm;
    assign editing   = r_editing;
    assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_aclk_time_entry.sv
// Directed bench for aclk_time_entry: digit entry, wrap/fixup, timeout,
// same-cycle button priority and reset during the load strobe.
module tb_aclk_time_entry;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] btn = '0;   // {cancel, ok, next, inc, mode_alarm, mode_time}
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, editing;
    logic [1:0] digit_sel;
    int         checks = 0;
    int         errors = 0;

    localparam logic [5:0] B_TIME = 6'b000001, B_ALARM = 6'b000010, B_INC = 6'b000100,
                           B_NEXT = 6'b001000, B_OK = 6'b010000, B_CANCEL = 6'b100000;

    aclk_time_entry #(.TIMEOUT_TICKS(300), .CNT_W(9)) dut (
        .clk(clk), .reset_n(reset_n),
        .mode_time(btn[0]), .mode_alarm(btn[1]), .btn_inc(btn[2]),
        .btn_next(btn[3]), .btn_ok(btn[4]), .btn_cancel(btn[5]),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            btn = m; step();
            btn = '0; step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; btn = '0;
        step(); step();
        checks++; if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin errors++;
            $display("FAIL reset_digits: got %h expected 0", {H_in1, H_in0, M_in1, M_in0}); end
        checks++; if ({LD_time, LD_alarm, editing, digit_sel} !== 5'd0) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {LD_time, LD_alarm, editing, digit_sel}); end
        reset_n = 1'b1; step();
    endtask

    task automatic test_time_entry();
        press(B_TIME, 1);
        checks++; if ({editing, digit_sel} !== 3'b100) begin errors++;
            $display("FAIL time_enter: got %b expected 100", {editing, digit_sel}); end
        press(B_INC, 1); press(B_NEXT, 1);
        press(B_INC, 3); press(B_NEXT, 1);
        press(B_INC, 4); press(B_NEXT, 1);
        press(B_INC, 5);
        checks++; if ({H_in1, H_in0, M_in1, M_in0} !== {2'd1, 4'd3, 4'd4, 4'd5}) begin errors++;
            $display("FAIL time_digits: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, {2'd1, 4'd3, 4'd4, 4'd5}); end
        checks++; if (digit_sel !== 2'd3) begin errors++;
            $display("FAIL time_sel: got %0d expected 3", digit_sel); end
        btn = B_OK; step();
        checks++; if ({LD_time, LD_alarm, editing} !== 3'b100) begin errors++;
            $display("FAIL time_load: got %b expected 100", {LD_time, LD_alarm, editing}); end
        btn = '0; step();
        checks++; if ({LD_time, LD_alarm, editing} !== 3'b000) begin errors++;
            $display("FAIL time_after_load: got %b expected 000", {LD_time, LD_alarm, editing}); end
        checks++; if ({H_in1, H_in0, M_in1, M_in0} !== {2'd1, 4'd3, 4'd4, 4'd5}) begin errors++;
            $display("FAIL time_hold: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, {2'd1, 4'd3, 4'd4, 4'd5}); end
    endtask

    task automatic test_alarm_fixup();
        logic [1:0] exp_h1 [3] = '{2'd1, 2'd2, 2'd0};
        press(B_ALARM, 1);
        checks++; if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin errors++;
            $display("FAIL alarm_clear: got %h expected 0", {H_in1, H_in0, M_in1, M_in0}); end
        for (int i = 0; i < 3; i++) begin
            press(B_INC, 1);
            checks++; if (H_in1 !== exp_h1[i]) begin errors++;
                $display("FAIL alarm_h1_wrap[%0d]: got %0d expected %0d", i, H_in1, exp_h1[i]); end
        end
        press(B_INC, 1); press(B_NEXT, 1); press(B_INC, 9);
        checks++; if ({H_in1, H_in0} !== {2'd1, 4'd9}) begin errors++;
            $display("FAIL alarm_19: got %h expected 19", {H_in1, H_in0}); end
        press(B_NEXT, 3); press(B_INC, 1);
        checks++; if ({H_in1, H_in0, M_in1, M_in0} !== {2'd2, 4'd0, 4'd0, 4'd0}) begin errors++;
            $display("FAIL alarm_fixup: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, {2'd2, 12'd0}); end
        btn = B_OK; step();
        checks++; if ({LD_time, LD_alarm} !== 2'b01) begin errors++;
            $display("FAIL alarm_load: got %b expected 01", {LD_time, LD_alarm}); end
        btn = '0; step();
        checks++; if ({LD_time, LD_alarm, editing} !== 3'b000) begin errors++;
            $display("FAIL alarm_after_load: got %b expected 000", {LD_time, LD_alarm, editing}); end
    endtask

    task automatic test_m1_and_next();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_m1 [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        press(B_TIME, 1);
        for (int i = 0; i < 4; i++) begin
            press(B_NEXT, 1);
            checks++; if (digit_sel !== exp_sel[i]) begin errors++;
                $display("FAIL next_sel[%0d]: got %0d expected %0d", i, digit_sel, exp_sel[i]); end
        end
        press(B_NEXT, 2);
        for (int i = 0; i < 6; i++) begin
            press(B_INC, 1);
            checks++; if (M_in1 !== exp_m1[i]) begin errors++;
                $display("FAIL m1_wrap[%0d]: got %0d expected %0d", i, M_in1, exp_m1[i]); end
        end
        // M1 now back at 0; give it a value that cancel must preserve
        press(B_INC, 2);
        btn = B_CANCEL; step();
        checks++; if ({LD_time, LD_alarm, editing} !== 3'b000) begin errors++;
            $display("FAIL cancel: got %b expected 000", {LD_time, LD_alarm, editing}); end
        btn = '0; step();
        checks++; if ({LD_time, LD_alarm, M_in1} !== {2'b00, 4'd2}) begin errors++;
            $display("FAIL cancel_hold: got %h expected 02", {LD_time, LD_alarm, M_in1}); end
    endtask

    task automatic test_timeout();
        int ld_seen = 0;
        btn = B_TIME; step(); btn = '0;
        for (int i = 0; i < 299; i++) begin
            step(); if (LD_time || LD_alarm) ld_seen++;
        end
        checks++; if (editing !== 1'b1) begin errors++;
            $display("FAIL timeout_early: editing got %b expected 1", editing); end
        step();
        checks++; if ({editing, LD_time, LD_alarm} !== 3'b000 || ld_seen != 0) begin errors++;
            $display("FAIL timeout_fire: got %b strobes %0d expected 000 and 0", {editing, LD_time, LD_alarm}, ld_seen); end
        // Inc one cycle before the timeout restarts the full count
        btn = B_TIME; step(); btn = '0;
        for (int i = 0; i < 298; i++) step();
        btn = B_INC; step(); btn = '0;
        for (int i = 0; i < 299; i++) step();
        checks++; if ({editing, H_in1} !== {1'b1, 2'd1}) begin errors++;
            $display("FAIL timeout_restart: got %b expected 101", {editing, H_in1}); end
        step();
        checks++; if ({editing, LD_time, LD_alarm} !== 3'b000) begin errors++;
            $display("FAIL timeout_restart_fire: got %b expected 000", {editing, LD_time, LD_alarm}); end
    endtask

    task automatic test_same_cycle();
        press(B_TIME, 1); press(B_INC, 1);
        btn = B_OK | B_INC; step();
        checks++; if ({LD_time, H_in1} !== {1'b1, 2'd1}) begin errors++;
            $display("FAIL ok_inc: got %b expected 101", {LD_time, H_in1}); end
        btn = '0; step();
        press(B_TIME, 1);
        checks++; if (H_in1 !== 2'd0) begin errors++;
            $display("FAIL reentry_clear: got %0d expected 0", H_in1); end
        btn = B_CANCEL | B_OK; step();
        checks++; if ({LD_time, LD_alarm, editing} !== 3'b000) begin errors++;
            $display("FAIL cancel_ok: got %b expected 000", {LD_time, LD_alarm, editing}); end
        btn = '0; step();
        checks++; if ({LD_time, LD_alarm} !== 2'b00) begin errors++;
            $display("FAIL cancel_ok_after: got %b expected 00", {LD_time, LD_alarm}); end
        press(B_TIME | B_ALARM, 1);
        btn = B_OK; step();
        checks++; if ({LD_time, LD_alarm} !== 2'b10) begin errors++;
            $display("FAIL both_modes: got %b expected 10", {LD_time, LD_alarm}); end
        btn = '0; step();
        press(B_TIME, 1);
        btn = B_INC;
        for (int i = 0; i < 20; i++) step();
        btn = '0; step();
        checks++; if (H_in1 !== 2'd1) begin errors++;
            $display("FAIL held_inc: got %0d expected 1", H_in1); end
        press(B_CANCEL, 1);
    endtask

    task automatic test_reset_in_load();
        press(B_TIME, 1); press(B_INC, 1);
        btn = B_OK; step();
        checks++; if (LD_time !== 1'b1) begin errors++;
            $display("FAIL rst_load_pre: got %b expected 1", LD_time); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({LD_time, LD_alarm, editing, H_in1} !== 5'd0) begin errors++;
            $display("FAIL rst_load_async: got %b expected 00000", {LD_time, LD_alarm, editing, H_in1}); end
        btn = '0; step();
        checks++; if ({LD_time, editing, H_in1, H_in0, M_in1, M_in0} !== 16'd0) begin errors++;
            $display("FAIL rst_load_held: got %h expected 0", {LD_time, editing, H_in1, H_in0, M_in1, M_in0}); end
        reset_n = 1'b1; step();
        press(B_TIME, 1);
        checks++; if ({editing, digit_sel} !== 3'b100) begin errors++;
            $display("FAIL rst_recover_enter: got %b expected 100", {editing, digit_sel}); end
        press(B_INC, 1);
        btn = B_OK; step();
        checks++; if ({LD_time, LD_alarm, H_in1} !== {2'b10, 2'd1}) begin errors++;
            $display("FAIL rst_recover_load: got %b expected 1001", {LD_time, LD_alarm, H_in1}); end
        btn = '0; step();
    endtask

    initial begin
        test_reset();
        test_time_entry();
        test_alarm_fixup();
        test_m1_and_next();
        test_timeout();
        test_same_cycle();
        test_reset_in_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
